// File: rtl/label_ptr_resolver_pkg.sv
// label_ptr_resolver_pkg: shared type codes, error codes and FSM encodings
// for the label pointer resolver. Build option: LBL_TYPE_CHECK_EN (used by
// label_bounds_chk) enables request-vs-table pointer type checking.
package label_ptr_resolver_pkg;

  // Table type code that marks an undefined label
  localparam logic [5:0] TYP_UNDEF = 6'd0;

  // Response error codes, highest priority first after OK
  localparam logic [1:0] ERR_OK     = 2'd0;
  localparam logic [1:0] ERR_UNDEF  = 2'd1;
  localparam logic [1:0] ERR_TYPE   = 2'd2;
  localparam logic [1:0] ERR_BOUNDS = 2'd3;

  // Resolver FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_RESP   = 2'd3
  } lpr_state_e;

  // 17-bit sum of base and offset; bit 16 is the carry-out
  function automatic logic [16:0] addr_sum17(input logic [15:0] base,
                                             input logic [15:0] off);
    addr_sum17 = {1'b0, base} + {1'b0, off};
  endfunction

endpackage

// File: rtl/label_ptr_resolver_bounds_chk.sv
// label_bounds_chk: combinational check of one label table entry against a
// request offset/type. Produces base+offset or an error code.
// Build option: LBL_TYPE_CHECK_EN enables the TYPE error (req type 0 = wildcard).
module label_bounds_chk
  import label_ptr_resolver_pkg::*;
(
  input  logic [15:0] i_base,
  input  logic [15:0] i_count,
  input  logic [15:0] i_off,
  input  logic [5:0]  i_typ,
  input  logic [5:0]  i_exp_typ,
  output logic [15:0] o_addr,
  output logic [1:0]  o_err
);

  logic [16:0] w_sum;
  logic        w_type_bad;

`ifdef LBL_TYPE_CHECK_EN
  assign w_type_bad = (i_exp_typ != TYP_UNDEF) && (i_typ != i_exp_typ);
`else
  // Requested type is not checked in this build
  logic w_unused_exp_typ;
  assign w_unused_exp_typ = ^i_exp_typ;
  assign w_type_bad       = 1'b0;
`endif

  // Prioritised error decode and address gating
  always_comb begin
    w_sum = addr_sum17(i_base, i_off);
    if (i_typ == TYP_UNDEF) begin
      o_err = ERR_UNDEF;
    end else if (w_type_bad) begin
      o_err = ERR_TYPE;
    end else if ((i_off >= i_count) || w_sum[16]) begin
      o_err = ERR_BOUNDS;
    end else begin
      o_err = ERR_OK;
    end
    if (o_err == ERR_OK) begin
      o_addr = w_sum[15:0];
    end else begin
      o_addr = 16'h0000;
    end
  end

endmodule

// File: rtl/label_ptr_resolver.sv
// label_ptr_resolver: resolves (label id, offset, expected type) requests
// against the label table into a checked 16-bit data address or error code.
// Four-state FSM (IDLE/LOOKUP/CHECK/RESP), all outputs registered.
// Build option: LBL_TYPE_CHECK_EN (see label_bounds_chk).
module label_ptr_resolver
  import label_ptr_resolver_pkg::*;
#(
  parameter int LBIDWidth = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [LBIDWidth-1:0] i_req_lbid,
  input  logic [15:0]          i_req_off,
  input  logic [5:0]           i_req_typ,
  output logic                 o_resp_valid,
  input  logic                 i_resp_ready,
  output logic [15:0]          o_resp_addr,
  output logic [1:0]           o_resp_err,
  output logic [LBIDWidth-1:0] o_lt_lbid,
  input  logic                 i_lt_we,
  input  logic [5:0]           i_lt_typ,
  input  logic [15:0]          i_lt_base,
  input  logic [15:0]          i_lt_count
);

  lpr_state_e           r_state;
  logic                 r_req_ready;
  logic                 r_resp_valid;
  logic [15:0]          r_resp_addr;
  logic [1:0]           r_resp_err;
  logic [LBIDWidth-1:0] r_lt_lbid;
  logic [15:0]          r_off;
  logic [5:0]           r_typ;

  logic [15:0]          w_addr;
  logic [1:0]           w_err;

  label_bounds_chk u_chk (
    .i_base    (i_lt_base),
    .i_count   (i_lt_count),
    .i_off     (r_off),
    .i_typ     (i_lt_typ),
    .i_exp_typ (r_typ),
    .o_addr    (w_addr),
    .o_err     (w_err)
  );

  // Resolver FSM: accept, wait for a table read, check, hold response
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_addr  <= 16'h0000;
      r_resp_err   <= ERR_OK;
      r_lt_lbid    <= '0;
      r_off        <= 16'h0000;
      r_typ        <= 6'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_req_valid && r_req_ready) begin
            r_lt_lbid   <= i_req_lbid;
            r_off       <= i_req_off;
            r_typ       <= i_req_typ;
            r_req_ready <= 1'b0;
            r_state     <= ST_LOOKUP;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_LOOKUP: begin
          // While the loader writes, the table is not reading our address
          if (!i_lt_we) begin
            r_state <= ST_CHECK;
          end else begin
            r_state <= ST_LOOKUP;
          end
        end
        ST_CHECK: begin
          r_resp_addr  <= w_addr;
          r_resp_err   <= w_err;
          r_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_lt_lbid    <= '0;
            r_req_ready  <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_state <= ST_RESP;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_req_ready  <= 1'b0;
          r_resp_valid <= 1'b0;
          r_lt_lbid    <= '0;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_addr  = r_resp_addr;
  assign o_resp_err   = r_resp_err;
  assign o_lt_lbid    = r_lt_lbid;

endmodule

// File: tb/tb_label_ptr_resolver.sv
// tb_label_ptr_resolver: directed + randomized bench for label_ptr_resolver
// with a behavioural label table and reference resolver.
module tb_label_ptr_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_lbid;
  logic [15:0] req_off;
  logic [5:0]  req_typ;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_addr;
  logic [1:0]  resp_err;
  logic [7:0]  lt_lbid;
  logic        lt_we;
  logic [5:0]  lt_typ;
  logic [15:0] lt_base;
  logic [15:0] lt_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0]  mem_typ   [256];
  logic [15:0] mem_base  [256];
  logic [15:0] mem_count [256];

  always #5 clk = ~clk;

  label_ptr_resolver #(.LBIDWidth(8)) dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_lbid   (req_lbid),
    .i_req_off    (req_off),
    .i_req_typ    (req_typ),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_addr  (resp_addr),
    .o_resp_err   (resp_err),
    .o_lt_lbid    (lt_lbid),
    .i_lt_we      (lt_we),
    .i_lt_typ     (lt_typ),
    .i_lt_base    (lt_base),
    .i_lt_count   (lt_count)
  );

  // Label table: synchronous read, data valid the cycle after the address when not writing
  always @(posedge clk) begin
    if (!lt_we) begin
      lt_typ   <= mem_typ[lt_lbid];
      lt_base  <= mem_base[lt_lbid];
      lt_count <= mem_count[lt_lbid];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference resolver from the table entry and request
  function automatic void ref_resolve(input int typ, input int base, input int cnt,
                                      input int off, input int rtyp,
                                      output int err, output int addr);
    int sum;
    sum = base + off;
    if (typ == 0) err = 1;
`ifdef LBL_TYPE_CHECK_EN
    else if (rtyp != 0 && rtyp != typ) err = 2;
`endif
    else if (off >= cnt || sum > 65535) err = 3;
    else err = 0;
    addr = (err == 0) ? sum : 0;
  endfunction

  // One complete transaction; directed=1 uses exp_err/exp_addr, else the model
  task automatic do_req(input int lbid, input int off, input int rtyp, input int stall,
                        input int hold, input bit directed, input int exp_err, input int exp_addr);
    int w, c, e_err, e_addr, h_addr, h_err;
    @(negedge clk);
    req_valid = 1'b1; req_lbid = 8'(lbid); req_off = 16'(off); req_typ = 6'(rtyp);
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (!req_ready) begin
      check_eq("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    c = 0;
    do begin
      @(negedge clk);
      c++;
      req_valid = 1'($urandom_range(0, 1));
      req_lbid = 8'($urandom); req_off = 16'($urandom); req_typ = 6'($urandom);
      if (!resp_valid) check_eq("lt_lbid_busy", 32'(lt_lbid), 32'(lbid));
      if (c <= stall) begin
        lt_we = 1'b1;
        if (!directed && $urandom_range(0, 1) == 1) begin
          mem_typ[lbid]   = 6'($urandom_range(0, 3));
          mem_base[lbid]  = 16'($urandom);
          mem_count[lbid] = 16'($urandom_range(0, 40));
        end
      end else if (c == stall + 1) begin
        lt_we = 1'b0;
      end else begin
        lt_we = directed ? 1'b0 : 1'($urandom_range(0, 1));
      end
    end while (!resp_valid && c < 40);
    check_eq("latency", 32'(c), 32'(3 + stall));
    if (directed) begin
      e_err = exp_err; e_addr = exp_addr;
    end else begin
      ref_resolve(int'(mem_typ[lbid]), int'(mem_base[lbid]), int'(mem_count[lbid]),
                  off, rtyp, e_err, e_addr);
    end
    check_eq("resp_err", 32'(resp_err), 32'(e_err));
    check_eq("resp_addr", 32'(resp_addr), 32'(e_addr));
    check_eq("lt_lbid_resp", 32'(lt_lbid), 32'(lbid));
    h_addr = e_addr; h_err = e_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      lt_we = 1'($urandom_range(0, 1));
      check_eq("hold_valid", 32'(resp_valid), 32'd1);
      check_eq("hold_addr", 32'(resp_addr), 32'(h_addr));
      check_eq("hold_err", 32'(resp_err), 32'(h_err));
      check_eq("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b0; lt_we = 1'b0;
    check_eq("done_valid", 32'(resp_valid), 32'd0);
    check_eq("done_ready", 32'(req_ready), 32'd1);
    check_eq("done_lbid", 32'(lt_lbid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_lbid = 8'd0; req_off = 16'd0; req_typ = 6'd0;
    resp_ready = 1'b0; lt_we = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem_typ[i] = 6'd0; mem_base[i] = 16'($urandom); mem_count[i] = 16'($urandom);
    end
    mem_typ[3] = 6'd2; mem_base[3] = 16'h0100; mem_count[3] = 16'd10;
    mem_typ[4] = 6'd1; mem_base[4] = 16'hFFF0; mem_count[4] = 16'h0100;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_addr", 32'(resp_addr), 32'd0);
    check_eq("rst_err", 32'(resp_err), 32'd0);
    check_eq("rst_lbid", 32'(lt_lbid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", 32'(req_ready), 32'd1);
    check_eq("post_rst_valid", 32'(resp_valid), 32'd0);

    // Directed cases
    do_req(3, 4, 2, 0, 0, 1'b1, 0, 16'h0104);
    do_req(3, 10, 2, 0, 0, 1'b1, 3, 0);
    do_req(3, 9, 2, 0, 0, 1'b1, 0, 16'h0109);
    do_req(7, 0, 0, 0, 0, 1'b1, 1, 0);
`ifdef LBL_TYPE_CHECK_EN
    do_req(3, 4, 5, 0, 0, 1'b1, 2, 0);
    do_req(3, 4, 0, 0, 0, 1'b1, 0, 16'h0104);
    do_req(7, 0, 5, 0, 0, 1'b1, 1, 0);
`else
    do_req(3, 4, 5, 0, 0, 1'b1, 0, 16'h0104);
`endif
    do_req(4, 16'h0020, 1, 0, 0, 1'b1, 3, 0);
    do_req(4, 16'h000F, 1, 0, 0, 1'b1, 0, 16'hFFFF);
    do_req(3, 5, 2, 5, 4, 1'b1, 0, 16'h0105);

    // Reset asserted while in CHECK drops the response
    @(negedge clk);
    req_valid = 1'b1; req_lbid = 8'd3; req_off = 16'd1; req_typ = 6'd2;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check_eq("midrst_valid", 32'(resp_valid), 32'd0);
    check_eq("midrst_ready", 32'(req_ready), 32'd0);
    check_eq("midrst_lbid", 32'(lt_lbid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("midrst_ready_after", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("midrst_no_resp", 32'(resp_valid), 32'd0);
    end
    do_req(3, 2, 2, 0, 0, 1'b1, 0, 16'h0102);

    // Randomized traffic against the reference model
    for (int i = 0; i < 16; i++) begin
      mem_typ[i]   = 6'($urandom_range(0, 3));
      mem_base[i]  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFC0 + $urandom_range(0, 63)) : 16'($urandom);
      mem_count[i] = 16'($urandom_range(0, 40));
    end
    for (int n = 0; n < 80; n++) begin
      int lb, of, rt, st, hd;
      lb = $urandom_range(0, 15);
      of = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 45));
      rt = $urandom_range(0, 3);
      st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      hd = $urandom_range(0, 2);
      do_req(lb, of, rt, st, hd, 1'b0, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
